// File: rtl/mult_op_sequencer.sv
// mult_op_sequencer
// Ready/valid front end for the pipelined array multiplier. Operand pairs are
// buffered in a small FIFO, issued one at a time, and the product is held on a
// ready/valid result port until it is consumed. A WAIT-state watchdog abandons
// an operation whose result never comes back and raises a sticky error.
// Optional build macro: MULT_SEQ_ZERO_SKIP_EN (zero operands bypass the multiplier).
module mult_op_sequencer #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_a,
    input  logic [WIDTH-1:0]     s_b,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [2*WIDTH-1:0]   m_z,
    output logic                 mul_valid,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_o_valid,
    input  logic [2*WIDTH-1:0]   mul_z,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   fifo_a [FIFO_DEPTH];
    logic [WIDTH-1:0]   fifo_b [FIFO_DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic               full, empty, push, pop;
    logic [WIDTH-1:0]   head_a, head_b;

    logic [WIDTH-1:0]   op_a, op_b;
    logic [WIDTH-1:0]   mul_a_hold, mul_b_hold;
    logic [2*WIDTH-1:0] m_z_q;
    logic [7:0]         wait_cnt;
    logic               err_q;

    logic               cnt_clr, capture, set_err, load_zero;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign s_ready = !full && !rst;
    assign push    = s_valid && s_ready;
    assign head_a  = fifo_a[rd_ptr[AW-1:0]];
    assign head_b  = fifo_b[rd_ptr[AW-1:0]];

    // Operand FIFO storage; data entries carry no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr[AW-1:0]] <= s_a;
            fifo_b[wr_ptr[AW-1:0]] <= s_b;
        end
    end

    // FIFO pointers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        cnt_clr   = 1'b0;
        capture   = 1'b0;
        set_err   = 1'b0;
        load_zero = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
`ifdef MULT_SEQ_ZERO_SKIP_EN
                    if (head_a == '0 || head_b == '0) begin
                        load_zero = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = ISSUE;
                    end
`else
                    state_nxt = ISSUE;
`endif
                end
            end
            ISSUE: begin
                cnt_clr   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A result arriving on the final WAIT cycle still wins.
                if (mul_o_valid) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end else if (wait_cnt == CNT_LAST) begin
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Wait counter: cleared on issue, counts every WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr)     wait_cnt <= '0;
        else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;
    end

    // Operand registers loaded on pop; issue registers keep the last issued pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            mul_a_hold <= '0;
            mul_b_hold <= '0;
        end else begin
            if (pop) begin
                op_a <= head_a;
                op_b <= head_b;
            end
            if (state == ISSUE) begin
                mul_a_hold <= op_a;
                mul_b_hold <= op_b;
            end
        end
    end

    // Result register: mul_z is only trusted while mul_o_valid is high in WAIT.
    always_ff @(posedge clk) begin
        if (rst)            m_z_q <= '0;
        else if (capture)   m_z_q <= mul_z;
        else if (load_zero) m_z_q <= '0;
    end

    // Sticky abandon flag.
    always_ff @(posedge clk) begin
        if (rst)          err_q <= 1'b0;
        else if (set_err) err_q <= 1'b1;
    end

    assign mul_valid   = (state == ISSUE);
    assign mul_a       = (state == ISSUE) ? op_a : mul_a_hold;
    assign mul_b       = (state == ISSUE) ? op_b : mul_b_hold;
    assign m_valid     = (state == HOLD);
    assign m_z         = m_z_q;
    assign busy        = (state != IDLE) || !empty;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_mult_op_sequencer.sv
// Bench for mult_op_sequencer: directed scenarios followed by randomized
// traffic, scored against a queue of expected products taken at push time.
module tb_mult_op_sequencer;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic [WIDTH-1:0]   s_a, s_b;
    logic               m_valid;
    logic               m_ready;
    logic [2*WIDTH-1:0] m_z;
    logic               mul_valid;
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic               mul_o_valid;
    logic [2*WIDTH-1:0] mul_z;
    logic               busy;
    logic               timeout_err;

    mult_op_sequencer #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_z(m_z),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_o_valid(mul_o_valid), .mul_z(mul_z),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stub: o_valid four cycles after the issue cycle, junk otherwise.
    bit                 stub_dead = 1'b0;
    logic [3:0]         pv = '0;
    logic [2*WIDTH-1:0] pz [4];
    always @(posedge clk) begin
        pv    <= {pv[2:0], mul_valid};
        pz[0] <= mul_a * mul_b;
        pz[1] <= pz[0];
        pz[2] <= pz[1];
        pz[3] <= pz[2];
    end
    assign mul_o_valid = pv[3] && !stub_dead;
    assign mul_z       = mul_o_valid ? pz[3] : 16'hDEAD;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: products expected, in push order.
    int exp_q[$];
    int n_results = 0;
    int n_issue = 0;
    int push_cyc = 0, mv_rise_cyc = 0, issue_cyc = 0, err_rise_cyc = 0;

    // Result monitor, sampled on the falling edge.
    initial begin
        logic               prev_mv, prev_mr, prev_mulv, prev_err;
        logic [2*WIDTH-1:0] prev_mz;
        prev_mv = 0; prev_mr = 0; prev_mulv = 0; prev_err = 0; prev_mz = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_valid && !prev_mv) mv_rise_cyc = cyc;
                if (timeout_err && !prev_err) err_rise_cyc = cyc;
                if (mul_valid) begin
                    chk("mul_valid_single", prev_mulv, 0);
                    n_issue++;
                    issue_cyc = cyc;
                end
                if (m_valid && prev_mv && !prev_mr) chk("m_z_stable", m_z, prev_mz);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) chk("spurious_result", m_valid, 0);
                    else chk("m_z", m_z, exp_q.pop_front());
                    n_results++;
                end
                prev_mv = m_valid; prev_mr = m_ready; prev_mulv = mul_valid;
                prev_err = timeout_err; prev_mz = m_z;
            end else begin
                prev_mv = 0; prev_mr = 0; prev_mulv = 0; prev_err = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_pair(input int a, input int b, input bit expect_res);
        bit acc;
        int t;
        acc = 0; t = 0;
        s_valid = 1'b1; s_a = WIDTH'(a); s_b = WIDTH'(b);
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = s_ready;
            if (acc) begin
                push_cyc = cyc;
                if (expect_res) exp_q.push_back(a * b);
            end
            @(posedge clk);
            #1;
            t++;
        end
        s_valid = 1'b0;
        chk("push_accepted", acc, 1);
    endtask

    task automatic wait_results(input int n);
        int t;
        t = 0;
        while (n_results < n && t < 400) begin
            tick(1);
            t++;
        end
        chk("result_count", n_results, n);
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        chk({tag, "_s_ready"},   s_ready, 1);
        chk({tag, "_m_valid"},   m_valid, 0);
        chk({tag, "_m_z"},       m_z, 0);
        chk({tag, "_mul_valid"}, mul_valid, 0);
        chk({tag, "_mul_a"},     mul_a, 0);
        chk({tag, "_mul_b"},     mul_b, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_err"},       timeout_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, iss0, d;
        bit drv_done;
        rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;

        // Reset state
        tick(2);
        @(negedge clk);
        chk("s_ready_in_rst", s_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values("rst");

        // Basic product with latency
        tick(1);
        m_ready = 1'b1;
        base = n_results; iss0 = n_issue;
        push_pair(13, 11, 1);
        wait_results(base + 1);
        chk("basic_latency", mv_rise_cyc - push_cyc, 7);
        chk("basic_issue_lat", issue_cyc - push_cyc, 2);
        chk("basic_issue_cnt", n_issue - iss0, 1);
        chk("basic_err", timeout_err, 0);

        // Max operands, then back-to-back second pair
        base = n_results;
        push_pair(255, 255, 1);
        push_pair(2, 3, 1);
        wait_results(base + 2);

        // Full FIFO under consumer back-pressure
        tick(2);
        m_ready = 1'b0;
        base = n_results;
        for (int i = 0; i < 5; i++) push_pair(i + 3, 2 * i + 1, 1);
        tick(8);
        @(negedge clk);
        chk("full_s_ready", s_ready, 0);
        chk("full_busy", busy, 1);
        chk("full_held", m_valid, 1);
        fork
            push_pair(21, 10, 1);
            begin
                tick(4);
                chk("blocked_still", n_results, base);
                m_ready = 1'b1;
            end
        join
        wait_results(base + 6);

        // Timeout with a dead multiplier
        tick(3);
        stub_dead = 1'b1;
        base = n_results;
        push_pair(7, 9, 0);
        tick(TIMEOUT + 6);
        chk("to_err", timeout_err, 1);
        d = err_rise_cyc - issue_cyc;
        chk("to_window", (d == TIMEOUT || d == TIMEOUT + 1), 1);
        chk("to_no_result", n_results, base);
        stub_dead = 1'b0;
        push_pair(4, 4, 1);
        wait_results(base + 1);
        chk("to_err_sticky", timeout_err, 1);

        // Reset in WAIT with two entries queued
        tick(2);
        push_pair(6, 7, 1);
        push_pair(8, 9, 1);
        push_pair(10, 11, 1);
        tick(1);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_s_ready", s_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        base = n_results;
        check_reset_values("midrst");
        tick(12);
        chk("late_ignored", n_results, base);
        chk("late_idle_busy", busy, 0);
        chk("late_m_valid", m_valid, 0);

        // Zero operand
        base = n_results; iss0 = n_issue;
        push_pair(0, 77, 1);
        wait_results(base + 1);
`ifdef MULT_SEQ_ZERO_SKIP_EN
        chk("zero_no_issue", n_issue - iss0, 0);
`else
        chk("zero_issue", n_issue - iss0, 1);
`endif

        // Randomized traffic with random consumer stalls
        base = n_results;
        drv_done = 0;
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    int a, b;
                    a = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
                    b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
                    push_pair(a, b, 1);
                    tick($urandom_range(0, 3));
                end
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    m_ready = ($urandom_range(0, 2) != 0);
                    tick(1);
                end
            end
        join
        m_ready = 1'b1;
        wait_results(base + 120);
        chk("drain_queue", exp_q.size(), 0);
        chk("rand_err", timeout_err, 0);
        tick(3);
        chk("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
